btb_bimodal_predictor: RTL and testbench



---
 rtl/btb_bimodal_predictor_if.sv | 25 ++
 rtl/btb_bimodal_predictor.sv | 75 +++++++
 tb/tb_btb_bimodal_predictor.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/btb_bimodal_predictor_if.sv
// btb_bimodal_predictor_if: fetch-predict and resolve-update bundle for the BTB predictor
// master (resolve/fetch side): drives pc and update_*, reads pred_* and mispredict_count
// slave (predictor): reads pc and update_*, drives pred_next_pc, pred_taken, mispredict_count
interface btb_bimodal_predictor_if #(
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 16
);
    logic [PC_WIDTH-1:0]  pc;
    logic [PC_WIDTH-1:0]  pred_next_pc;
    logic                 pred_taken;
    logic                 update_valid;
    logic [PC_WIDTH-1:0]  update_pc;
    logic                 update_taken;
    logic [PC_WIDTH-1:0]  update_target;
    logic                 update_mispredict;
    logic [CNT_WIDTH-1:0] mispredict_count;
    modport master (
        output pc, update_valid, update_pc, update_taken, update_target, update_mispredict,
        input  pred_next_pc, pred_taken, mispredict_count
    );
    modport slave (
        input  pc, update_valid, update_pc, update_taken, update_target, update_mispredict,
        output pred_next_pc, pred_taken, mispredict_count
    );
endinterface

// File: rtl/btb_bimodal_predictor.sv
// btb_bimodal_predictor: direct-mapped tagged BTB with a 2-bit saturating counter per entry
// Ports: clk; reset (synchronous, active-high); bp (slave modport) carrying the fetch pc,
//   the combinational prediction, the resolve-stage update port and the saturating
//   mispredict_count.
// Optional: define BP_GSHARE_EN to XOR a global history register into the counter index.
module btb_bimodal_predictor #(
    parameter int PC_WIDTH   = 16,
    parameter int INDEX_BITS = 8,
    parameter int GHR_BITS   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input logic                    clk,
    input logic                    reset,
    btb_bimodal_predictor_if.slave bp
);
    localparam int N  = 1 << INDEX_BITS;
    localparam int TW = PC_WIDTH - INDEX_BITS;
    logic [N-1:0]          r_valid;
    logic [TW-1:0]         r_tag    [N];
    logic [PC_WIDTH-1:0]   r_target [N];
    logic [1:0]            r_cnt    [N];
    logic [CNT_WIDTH-1:0]  r_miss;
    logic [GHR_BITS-1:0]   w_hist;
    logic [INDEX_BITS-1:0] w_idx, w_cidx, w_uidx, w_ucidx;
    logic [TW-1:0]         w_tag, w_utag;
    logic                  w_hit, w_uhit, w_taken;
    logic [1:0]            w_ucnt, w_ucnt_nx;
`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] r_ghr;
    always_ff @(posedge clk) begin
        if (reset) r_ghr <= '0;
        else if (bp.update_valid) r_ghr <= GHR_BITS'({r_ghr, bp.update_taken});
    end
    assign w_hist = r_ghr;
`else
    assign w_hist = '0;
`endif
    assign w_idx   = bp.pc[INDEX_BITS-1:0];
    assign w_tag   = bp.pc[PC_WIDTH-1:INDEX_BITS];
    assign w_uidx  = bp.update_pc[INDEX_BITS-1:0];
    assign w_utag  = bp.update_pc[PC_WIDTH-1:INDEX_BITS];
    // counters may be history-hashed; tag/target always use the plain index
    assign w_cidx  = w_idx ^ INDEX_BITS'(w_hist);
    assign w_ucidx = w_uidx ^ INDEX_BITS'(w_hist);
    assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_uhit  = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_taken = !reset && w_hit && r_cnt[w_cidx][1];
    assign w_ucnt  = r_cnt[w_ucidx];
    assign w_ucnt_nx = bp.update_taken ? (w_ucnt == 2'b11 ? 2'b11 : w_ucnt + 2'd1)
                                       : (w_ucnt == 2'b00 ? 2'b00 : w_ucnt - 2'd1);
    assign bp.pred_taken       = w_taken;
    assign bp.pred_next_pc     = w_taken ? r_target[w_idx] : bp.pc + PC_WIDTH'(1);
    assign bp.mispredict_count = r_miss;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_miss  <= '0;
            for (int i = 0; i < N; i++) r_cnt[i] <= 2'b01;
        end else begin
            if (bp.update_valid && w_uhit) r_cnt[w_ucidx] <= w_ucnt_nx;
            else if (bp.update_valid && bp.update_taken) begin
                r_valid[w_uidx] <= 1'b1;
                r_cnt[w_ucidx]  <= 2'b10;
            end
            if (bp.update_valid && bp.update_mispredict && !(&r_miss)) r_miss <= r_miss + CNT_WIDTH'(1);
        end
    end
    // tag/target carry no reset; the tag rewrite on a hit stores the same value
    always_ff @(posedge clk) begin
        if (!reset && bp.update_valid && bp.update_taken) begin
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= bp.update_target;
        end
    end
endmodule

// File: tb/tb_btb_bimodal_predictor.sv
// tb_btb_bimodal_predictor: vector table, corner sequences and randomized model check
module tb_btb_bimodal_predictor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int tk, nx;
    always #5 clk = ~clk;

    btb_bimodal_predictor_if #(.PC_WIDTH(16), .CNT_WIDTH(16)) u_if ();
    btb_bimodal_predictor_if #(.PC_WIDTH(16), .CNT_WIDTH(2))  s_if ();

    btb_bimodal_predictor #(.PC_WIDTH(16), .INDEX_BITS(8), .GHR_BITS(4), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .bp(u_if.slave));
    btb_bimodal_predictor #(.PC_WIDTH(16), .INDEX_BITS(8), .GHR_BITS(4), .CNT_WIDTH(2)) s_dut (
        .clk(clk), .reset(reset), .bp(s_if.slave));

    int m_valid [256];
    int m_tag   [256];
    int m_tgt   [256];
    int m_cnt   [256];
    int m_ghr = 0;
    int m_miss = 0;

    typedef struct {int pc, uv, upc, ut, utgt, um, etk, enx;} vec_t;
    vec_t tbl [$];

    function automatic void check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic int cnt_idx(int idx);
`ifdef BP_GSHARE_EN
        return idx ^ m_ghr;
`else
        return idx;
`endif
    endfunction

    function automatic void model_predict(int pc, int rst, output int etk, output int enx);
        int idx = pc % 256;
        etk = (rst == 0 && m_valid[idx] != 0 && m_tag[idx] == pc / 256 && m_cnt[cnt_idx(idx)] >= 2) ? 1 : 0;
        enx = (etk != 0) ? m_tgt[idx] : (pc + 1) % 65536;
    endfunction

    function automatic void model_update(int rst, int uv, int upc, int ut, int utgt, int um);
        int idx = upc % 256;
        int c = cnt_idx(idx);
        if (rst != 0) begin
            for (int i = 0; i < 256; i++) begin
                m_valid[i] = 0;
                m_cnt[i] = 1;
            end
            m_ghr = 0;
            m_miss = 0;
            return;
        end
        if (uv == 0) return;
        if (m_valid[idx] != 0 && m_tag[idx] == upc / 256) begin
            if (ut != 0) begin
                m_cnt[c] = (m_cnt[c] == 3) ? 3 : m_cnt[c] + 1;
                m_tgt[idx] = utgt;
            end else m_cnt[c] = (m_cnt[c] == 0) ? 0 : m_cnt[c] - 1;
        end else if (ut != 0) begin
            m_valid[idx] = 1;
            m_tag[idx] = upc / 256;
            m_tgt[idx] = utgt;
            m_cnt[c] = 2;
        end
        if (um != 0 && m_miss < 65535) m_miss++;
        m_ghr = ((m_ghr << 1) | ut) % 16;
    endfunction

    task automatic cyc(input string name, input int rst, input int pc, input int uv, input int upc,
                       input int ut, input int utgt, input int um, output int otk, output int onx);
        int etk, enx;
        reset = (rst != 0);
        u_if.pc = 16'(pc);
        u_if.update_valid = (uv != 0);
        u_if.update_pc = 16'(upc);
        u_if.update_taken = (ut != 0);
        u_if.update_target = 16'(utgt);
        u_if.update_mispredict = (um != 0);
        #1;
        otk = int'(u_if.pred_taken);
        onx = int'(u_if.pred_next_pc);
        model_predict(pc, rst, etk, enx);
        check({name, " taken"}, otk, etk);
        check({name, " next_pc"}, onx, enx);
        if (rst == 0) check({name, " count"}, int'(u_if.mispredict_count), m_miss);
        @(posedge clk);
        model_update(rst, uv, upc, ut, utgt, um);
        #1;
    endtask

    initial begin
        s_if.pc = '0;
        s_if.update_valid = 1'b0;
        s_if.update_pc = '0;
        s_if.update_taken = 1'b0;
        s_if.update_target = '0;
        s_if.update_mispredict = 1'b0;
        // pc, uv, upc, ut, utgt, um, expected taken, expected next pc
        tbl.push_back('{'h0040, 0, 0,      0, 0,      0, 0, 'h0041});
        tbl.push_back('{'h0040, 1, 'h0040, 1, 'h0100, 0, 0, 'h0041});
        tbl.push_back('{'h0040, 0, 0,      0, 0,      0, 1, 'h0100});
        tbl.push_back('{'h1240, 0, 0,      0, 0,      0, 0, 'h1241});
        tbl.push_back('{'h0040, 1, 'h0040, 1, 'h0100, 0, 1, 'h0100});
        tbl.push_back('{'h0040, 1, 'h0040, 1, 'h0100, 0, 1, 'h0100});
        tbl.push_back('{'h0040, 1, 'h0040, 0, 0,      0, 1, 'h0100});
        tbl.push_back('{'h0040, 0, 0,      0, 0,      0, 1, 'h0100});
        tbl.push_back('{'h0040, 1, 'h0040, 0, 0,      0, 1, 'h0100});
        tbl.push_back('{'h0040, 1, 'h0040, 0, 0,      0, 0, 'h0041});
        tbl.push_back('{'h0040, 1, 'h0040, 0, 0,      0, 0, 'h0041});
        tbl.push_back('{'h0040, 1, 'h0040, 1, 'h0100, 0, 0, 'h0041});
        tbl.push_back('{'h0040, 0, 0,      0, 0,      0, 0, 'h0041});
        tbl.push_back('{'hFFFF, 0, 0,      0, 0,      0, 0, 'h0000});
        tbl.push_back('{'h0050, 1, 'h0050, 0, 'h0200, 0, 0, 'h0051});
        tbl.push_back('{'h0050, 0, 0,      0, 0,      0, 0, 'h0051});
        tbl.push_back('{'h0060, 1, 'h0060, 1, 'h0300, 0, 0, 'h0061});
        tbl.push_back('{'h0060, 0, 0,      0, 0,      0, 1, 'h0300});
        tbl.push_back('{'h0060, 1, 'h0060, 1, 'h0400, 1, 1, 'h0300});
        tbl.push_back('{'h0060, 0, 0,      0, 0,      0, 1, 'h0400});

        cyc("reset0", 1, 'h0040, 0, 0, 0, 0, 0, tk, nx);
        cyc("reset1", 1, 'h0040, 0, 0, 0, 0, 0, tk, nx);
        check("reset count", int'(u_if.mispredict_count), 0);
        check("reset sat count", int'(s_if.mispredict_count), 0);
`ifndef BP_GSHARE_EN
        foreach (tbl[i]) begin
            cyc($sformatf("vec%0d", i), 0, tbl[i].pc, tbl[i].uv, tbl[i].upc, tbl[i].ut,
                tbl[i].utgt, tbl[i].um, tk, nx);
            check($sformatf("vec%0d tbl_taken", i), tk, tbl[i].etk);
            check($sformatf("vec%0d tbl_next_pc", i), nx, tbl[i].enx);
        end
        check("table count", int'(u_if.mispredict_count), 1);
`endif
        // update presented together with reset must not allocate
        cyc("rst_upd", 1, 'h0070, 1, 'h0070, 1, 'h0500, 1, tk, nx);
        check("rst_upd taken", tk, 0);
        check("rst_upd next_pc", nx, 'h0071);
        cyc("after_rst", 0, 'h0070, 0, 0, 0, 0, 0, tk, nx);
        check("after_rst taken", tk, 0);
        check("after_rst next_pc", nx, 'h0071);
        check("after_rst count", int'(u_if.mispredict_count), 0);
        cyc("after_rst60", 0, 'h0060, 0, 0, 0, 0, 0, tk, nx);
        check("after_rst60 next_pc", nx, 'h0061);

        // 2-bit statistics counter: five valid pulses, one ignored pulse without valid
        begin
            int pulses = 0;
            for (int i = 0; i < 6; i++) begin
                s_if.update_valid = (i != 2);
                s_if.update_mispredict = 1'b1;
                if (i != 2) pulses++;
                @(posedge clk);
                #1;
                check($sformatf("sat_count%0d", i), int'(s_if.mispredict_count), pulses > 3 ? 3 : pulses);
            end
            s_if.update_valid = 1'b0;
            s_if.update_mispredict = 1'b0;
        end

        for (int i = 0; i < 3000; i++) begin
            int pc  = ($urandom_range(0, 15) == 0) ? 'hFFFF : int'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
            int upc = int'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
            cyc("rnd", ($urandom_range(0, 99) == 0) ? 1 : 0, pc, int'($urandom_range(0, 1)), upc,
                int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                ($urandom_range(0, 3) == 0) ? 1 : 0, tk, nx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
